// File: rtl/sdcmd_responder.sv
// SD SPI-mode command responder: hunts 6-byte command frames on the MOSI byte stream,
// tracks card init state and returns R1/R3/R7 responses on the MISO byte register.
`timescale 1ns/1ps
module sdcmd_responder #(
  parameter int          NCR        = 1,
  parameter int          INIT_POLLS = 2,
  parameter logic [31:0] OCR        = 32'h40FF8000,
  parameter bit          CRC_CHECK  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        idle
);

  typedef enum logic [1:0] {HUNT, RECV, NCR_WAIT, RESP} state_t;

  localparam logic [3:0] NCR_LOAD    = 4'(NCR);
  localparam logic [3:0] INIT_RELOAD = 4'(INIT_POLLS);

  state_t      state, next_state;
  logic [2:0]  byte_cnt;
  logic [37:0] frame_buf;
  logic [6:0]  crc;
  logic [39:0] resp_buf;
  logic [2:0]  resp_left;
  logic [3:0]  ncr_cnt;
  logic [3:0]  init_cnt;
  logic        app_cmd;

  logic        start_byte;
  logic        byte_in;
  logic [5:0]  dec_index;
  logic [31:0] dec_arg;
  logic        crc_err;
  logic        illegal;
  logic        dp_accept;
  logic [7:0]  r1;
  logic [39:0] resp_d;
  logic [2:0]  resp_len_d;

  function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign start_byte = (rx_data[7:6] == 2'b01);
  assign byte_in    = rx_valid && !cs_n;
  assign dec_index  = frame_buf[37:32];
  assign dec_arg    = frame_buf[31:0];
  assign crc_err    = !rx_data[0] || (CRC_CHECK && (crc != rx_data[7:1]));

  // Command decode, evaluated against the final frame byte on rx_data.
  always_comb begin
    illegal    = 1'b0;
    dp_accept  = 1'b0;
    resp_len_d = 3'd1;
    if (!crc_err) begin
      case (dec_index)
        6'd0, 6'd55: begin
        end
        6'd8:  resp_len_d = 3'd5;
        6'd41: illegal = !app_cmd;
        6'd58: resp_len_d = 3'd5;
        6'd16, 6'd17, 6'd24: begin
          if (idle) illegal   = 1'b1;
          else      dp_accept = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
    r1     = {4'b0000, crc_err, illegal, 1'b0, idle};
    resp_d = {r1, 32'h0000_0000};
    if (!crc_err && dec_index == 6'd8)
      resp_d = {r1, 16'h0000, 4'h0, dec_arg[11:8], dec_arg[7:0]};
    else if (!crc_err && dec_index == 6'd58)
      resp_d = {r1, ~idle, OCR[30:0]};
  end

  always_comb begin
    next_state = state;
    if (cs_n) begin
      next_state = HUNT;
    end else if (rx_valid) begin
      case (state)
        HUNT:     if (start_byte)         next_state = RECV;
        RECV:     if (byte_cnt == 3'd5)   next_state = NCR_WAIT;
        NCR_WAIT: if (ncr_cnt == 4'd1)    next_state = RESP;
        RESP:     if (resp_left == 3'd1)  next_state = HUNT;
        default:                          next_state = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= next_state;
  end

  // Datapath: frame capture, command execution and response sequencing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data   <= 8'hFF;
      busy      <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_index <= 6'd0;
      cmd_arg   <= 32'd0;
      idle      <= 1'b1;
      app_cmd   <= 1'b0;
      init_cnt  <= INIT_RELOAD;
      byte_cnt  <= 3'd0;
      frame_buf <= '0;
      crc       <= 7'd0;
      resp_buf  <= '0;
      resp_left <= 3'd0;
      ncr_cnt   <= 4'd0;
    end else begin
      cmd_valid <= 1'b0;
      if (cs_n) begin
        tx_data <= 8'hFF;
        busy    <= 1'b0;
      end else if (byte_in) begin
        case (state)
          HUNT: begin
            tx_data <= 8'hFF;
            if (start_byte) begin
              frame_buf <= {frame_buf[29:0], rx_data};
              crc       <= crc7_byte(7'd0, rx_data);
              byte_cnt  <= 3'd1;
              busy      <= 1'b1;
            end
          end
          RECV: begin
            tx_data <= 8'hFF;
            if (byte_cnt != 3'd5) begin
              frame_buf <= {frame_buf[29:0], rx_data};
              crc       <= crc7_byte(crc, rx_data);
              byte_cnt  <= byte_cnt + 3'd1;
            end else begin
              resp_buf  <= resp_d;
              resp_left <= resp_len_d;
              ncr_cnt   <= NCR_LOAD;
              app_cmd   <= 1'b0;
              if (!crc_err) begin
                case (dec_index)
                  6'd0: begin
                    idle     <= 1'b1;
                    init_cnt <= INIT_RELOAD;
                  end
                  6'd55: app_cmd <= 1'b1;
                  6'd41: begin
                    if (app_cmd) begin
                      if (init_cnt <= 4'd1) begin
                        init_cnt <= 4'd0;
                        idle     <= 1'b0;
                      end else begin
                        init_cnt <= init_cnt - 4'd1;
                      end
                    end
                  end
                  default: begin
                  end
                endcase
              end
              if (dp_accept) begin
                cmd_valid <= 1'b1;
                cmd_index <= dec_index;
                cmd_arg   <= dec_arg;
              end
            end
          end
          NCR_WAIT: begin
            if (ncr_cnt == 4'd1) begin
              tx_data  <= resp_buf[39:32];
              resp_buf <= {resp_buf[31:0], 8'hFF};
            end else begin
              tx_data <= 8'hFF;
              ncr_cnt <= ncr_cnt - 4'd1;
            end
          end
          RESP: begin
            // Incoming bytes only pace the response; no hunting until it is fully sent.
            if (resp_left == 3'd1) begin
              tx_data <= 8'hFF;
              busy    <= 1'b0;
            end else begin
              tx_data   <= resp_buf[39:32];
              resp_buf  <= {resp_buf[31:0], 8'hFF};
              resp_left <= resp_left - 3'd1;
            end
          end
          default: tx_data <= 8'hFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdcmd_responder.sv
// Directed self-checking bench for sdcmd_responder: init sequence, R1/R3/R7 formats,
// data-path handoff, CRC errors, deselect abort and asynchronous reset during a response.
`timescale 1ns/1ps
module tb_sdcmd_responder;

  localparam int NCR = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        busy;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        idle;

  int checks   = 0;
  int failures = 0;
  int cvCycles = 0;

  sdcmd_responder #(.NCR(NCR), .INIT_POLLS(2), .OCR(32'h40FF8000), .CRC_CHECK(1'b1)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .busy(busy), .cmd_valid(cmd_valid), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .idle(idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cmd_valid === 1'b1) cvCycles++;

  // Long-division form of CRC7 (x^7+x^3+1) over a 40-bit message.
  function automatic logic [6:0] crc7(input logic [39:0] msg);
    logic [46:0] m;
    m = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
    return m[6:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [39:0] observed, input logic [39:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // One byte exchange; miso is the byte the card shifted out during it.
  task automatic applyStimulus(input logic [7:0] mosi, output logic [7:0] miso);
    miso     = tx_data;
    rx_data  = mosi;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic sendCmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic badEnd, input int nresp, input logic [39:0] exp);
    logic [47:0] frame;
    logic [7:0]  miso;
    frame[47:8] = {2'b01, idx, arg};
    frame[7:0]  = {crc7(frame[47:8]), ~badEnd};
    for (int i = 0; i < 6; i++) applyStimulus(frame[47-8*i -: 8], miso);
    for (int i = 0; i < NCR; i++) begin
      applyStimulus(8'hFF, miso);
      checkOutput({tag, "_ncr"}, 40'(miso), 40'h0FF);
    end
    for (int i = 0; i < nresp; i++) begin
      applyStimulus(8'hFF, miso);
      checkOutput($sformatf("%s_r%0d", tag, i), 40'(miso), 40'(exp[39-8*i -: 8]));
    end
    applyStimulus(8'hFF, miso);
    checkOutput({tag, "_tail"}, 40'(miso), 40'h0FF);
    checkOutput({tag, "_busy"}, 40'(busy), 40'h0);
  endtask

  initial begin
    int cvBefore;
    logic [7:0] miso;
    logic [47:0] cmd8;

    reset = 1'b1; cs_n = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tx",    40'(tx_data),   40'h0FF);
    checkOutput("rst_busy",  40'(busy),      40'h0);
    checkOutput("rst_idle",  40'(idle),      40'h1);
    checkOutput("rst_cv",    40'(cmd_valid), 40'h0);
    checkOutput("rst_index", 40'(cmd_index), 40'h0);
    checkOutput("rst_arg",   40'(cmd_arg),   40'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    cs_n = 1'b0;
    @(posedge clk); #1;

    sendCmd("cmd0",  6'd0,  32'h0,     1'b0, 1, 40'h01_00000000);
    checkOutput("cmd0_idle", 40'(idle), 40'h1);
    sendCmd("cmd8",  6'd8,  32'h1AA,   1'b0, 5, 40'h01_0000_01AA);
    sendCmd("cmd58a", 6'd58, 32'h0,    1'b0, 5, 40'h01_40FF_8000);

    cvBefore = cvCycles;
    sendCmd("cmd17_idle", 6'd17, 32'h200, 1'b0, 1, 40'h05_00000000);
    checkOutput("cmd17_idle_cv", 40'(cvCycles - cvBefore), 40'h0);
    sendCmd("bare41", 6'd41, 32'h40000000, 1'b0, 1, 40'h05_00000000);
    sendCmd("cmd2",   6'd2,  32'h0,        1'b0, 1, 40'h05_00000000);

    sendCmd("pre55",  6'd55, 32'h0,        1'b0, 1, 40'h01_00000000);
    sendCmd("badcrc", 6'd0,  32'h0,        1'b1, 1, 40'h09_00000000);
    sendCmd("post41", 6'd41, 32'h40000000, 1'b0, 1, 40'h05_00000000);
    checkOutput("badcrc_idle", 40'(idle), 40'h1);

    sendCmd("i55a", 6'd55, 32'h0,        1'b0, 1, 40'h01_00000000);
    sendCmd("i41a", 6'd41, 32'h40000000, 1'b0, 1, 40'h01_00000000);
    checkOutput("i41a_idle", 40'(idle), 40'h1);
    sendCmd("i55b", 6'd55, 32'h0,        1'b0, 1, 40'h01_00000000);
    sendCmd("i41b", 6'd41, 32'h40000000, 1'b0, 1, 40'h01_00000000);
    checkOutput("init_idle", 40'(idle), 40'h0);
    sendCmd("cmd58b", 6'd58, 32'h0, 1'b0, 5, 40'h00_C0FF_8000);

    cvBefore = cvCycles;
    sendCmd("cmd17", 6'd17, 32'h200, 1'b0, 1, 40'h00_00000000);
    checkOutput("cmd17_cv",    40'(cvCycles - cvBefore), 40'h1);
    checkOutput("cmd17_index", 40'(cmd_index), 40'd17);
    checkOutput("cmd17_arg",   40'(cmd_arg),   40'h200);
    cvBefore = cvCycles;
    sendCmd("cmd24", 6'd24, 32'h12345678, 1'b0, 1, 40'h00_00000000);
    checkOutput("cmd24_cv",    40'(cvCycles - cvBefore), 40'h1);
    checkOutput("cmd24_index", 40'(cmd_index), 40'd24);
    checkOutput("cmd24_arg",   40'(cmd_arg),   40'h12345678);

    // Partial CMD8 dropped by a deselect pulse.
    applyStimulus(8'h48, miso);
    applyStimulus(8'h00, miso);
    applyStimulus(8'h00, miso);
    checkOutput("abort_busy_pre", 40'(busy), 40'h1);
    cs_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_busy", 40'(busy),    40'h0);
    checkOutput("abort_tx",   40'(tx_data), 40'h0FF);
    cs_n = 1'b0;
    @(posedge clk); #1;
    sendCmd("abort_cmd0", 6'd0, 32'h0, 1'b0, 1, 40'h00_00000000);
    checkOutput("abort_idle", 40'(idle), 40'h1);

    sendCmd("j55a", 6'd55, 32'h0,        1'b0, 1, 40'h01_00000000);
    sendCmd("j41a", 6'd41, 32'h40000000, 1'b0, 1, 40'h01_00000000);
    sendCmd("j55b", 6'd55, 32'h0,        1'b0, 1, 40'h01_00000000);
    sendCmd("j41b", 6'd41, 32'h40000000, 1'b0, 1, 40'h01_00000000);
    checkOutput("reinit_idle", 40'(idle), 40'h0);

    // CMD8 interrupted by reset partway through its R7.
    cmd8 = 48'h48_000001AA_87;
    for (int i = 0; i < 6; i++) applyStimulus(cmd8[47-8*i -: 8], miso);
    applyStimulus(8'hFF, miso);
    applyStimulus(8'hFF, miso);
    checkOutput("rr_r0", 40'(miso), 40'h00);
    applyStimulus(8'hFF, miso);
    checkOutput("rr_r1", 40'(miso), 40'h00);
    reset = 1'b1;
    #1;
    checkOutput("rr_tx",    40'(tx_data),   40'h0FF);
    checkOutput("rr_idle",  40'(idle),      40'h1);
    checkOutput("rr_busy",  40'(busy),      40'h0);
    checkOutput("rr_index", 40'(cmd_index), 40'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    sendCmd("post_rst", 6'd58, 32'h0, 1'b0, 5, 40'h01_40FF_8000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
